shape_raster: RTL and testbench

Parametrised shape rasteriser, the successor to the rect/line drawer in the graphics path. It takes a shape command and emits one pixel coordinate per handshake on a valid/ready stream toward the framebuffer writer. It generalises coordinate width and draws true Bresenham lines in all octants. It emits each rectangle-outline pixel exactly once, honours downstream backpressure, and supports abort.

---
 rtl/shape_pkg.sv | 29 ++
 rtl/bresenham_step.sv | 43 ++++
 rtl/shape_raster.sv | 232 +++++++++++++++++++++++
 tb/tb_shape_raster.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_pkg.sv
// shape_pkg: shape codes, FSM state encoding and error-term width rule.
// SHAPE_RASTER_FILL_EN compiles in the filled-rectangle state.
package shape_pkg;

    localparam logic [1:0] SHAPE_NONE = 2'd0;
    localparam logic [1:0] SHAPE_RECT = 2'd1;
    localparam logic [1:0] SHAPE_LINE = 2'd2;
    localparam logic [1:0] SHAPE_FILL = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SETUP      = 4'd1,
        ST_RECT_TOP   = 4'd2,
        ST_RECT_RIGHT = 4'd3,
        ST_RECT_BOT   = 4'd4,
        ST_RECT_LEFT  = 4'd5,
`ifdef SHAPE_RASTER_FILL_EN
        ST_FILL       = 4'd6,
`endif
        ST_LINE       = 4'd7,
        ST_FINISH     = 4'd8
    } state_t;

    // Two extra bits hold 2*err for any pair of CW-bit endpoints.
    function automatic int err_w(input int cw);
        return cw + 2;
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: one combinational Bresenham advance of (x, y, err).
// Both axis tests use the same e2 taken from the incoming error term.
module bresenham_step
    import shape_pkg::*;
#(
    parameter int CW = 8,
    parameter int EW = err_w(CW)
) (
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    output logic [CW-1:0]        nx,
    output logic [CW-1:0]        ny,
    output logic signed [EW-1:0] nerr
);

    logic signed [EW-1:0] e2;
    logic                 step_x;
    logic                 step_y;

    // Decide which axes move and accumulate the error term.
    always_comb begin
        e2     = err <<< 1;
        step_x = (e2 >= dy);
        step_y = (e2 <= dx);
        nerr   = err;
        nx     = x;
        ny     = y;
        if (step_x) begin
            nerr = nerr + dy;
            nx   = sx_neg ? x - CW'(1) : x + CW'(1);
        end
        if (step_y) begin
            nerr = nerr + dx;
            ny   = sy_neg ? y - CW'(1) : y + CW'(1);
        end
    end

endmodule

// File: rtl/shape_raster.sv
// shape_raster: rect outline / Bresenham line (/ optional fill) rasteriser
// streaming one pixel per valid/ready handshake. Fill: SHAPE_RASTER_FILL_EN.
module shape_raster
    import shape_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    shape,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    input  logic          abort,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic          px_valid,
    input  logic          px_ready,
    output logic          busy,
    output logic          done
);

    localparam int EW = err_w(CW);

    state_t state, state_n;

    logic [1:0]           shp;
    logic [CW-1:0]        lx0, ly0, lx1, ly1;
    logic [CW-1:0]        min_x, max_x, min_y, max_y;
    logic [CW-1:0]        cur_x, cur_y;
    logic signed [EW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;

    logic [CW-1:0]        mn_x, mx_x, mn_y, mx_y;
    logic signed [EW-1:0] ex0, ey0, ex1, ey1, adx, ady;
    logic [CW-1:0]        bx, by;
    logic signed [EW-1:0] berr;
    logic                 legal;
    logic                 hs;
    logic                 line_end;

    assign hs       = px_valid & px_ready;
    assign line_end = (cur_x == lx1) && (cur_y == ly1);
    assign px_x     = cur_x;
    assign px_y     = cur_y;

    assign mn_x = (lx0 < lx1) ? lx0 : lx1;
    assign mx_x = (lx0 < lx1) ? lx1 : lx0;
    assign mn_y = (ly0 < ly1) ? ly0 : ly1;
    assign mx_y = (ly0 < ly1) ? ly1 : ly0;

    assign ex0 = signed'(EW'(lx0));
    assign ey0 = signed'(EW'(ly0));
    assign ex1 = signed'(EW'(lx1));
    assign ey1 = signed'(EW'(ly1));
    assign adx = (ex1 >= ex0) ? ex1 - ex0 : ex0 - ex1;
    assign ady = (ey1 >= ey0) ? ey1 - ey0 : ey0 - ey1;

    bresenham_step #(.CW(CW), .EW(EW)) u_step (
        .x      (cur_x),
        .y      (cur_y),
        .err    (err),
        .dx     (dx),
        .dy     (dy),
        .sx_neg (sx_neg),
        .sy_neg (sy_neg),
        .nx     (bx),
        .ny     (by),
        .nerr   (berr)
    );

    // Which shape codes start a command in this build.
    always_comb begin
        legal = 1'b0;
        unique case (shape)
            SHAPE_RECT, SHAPE_LINE: legal = 1'b1;
`ifdef SHAPE_RASTER_FILL_EN
            SHAPE_FILL: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state: abort wins, walks advance only on a handshake.
    always_comb begin
        state_n = state;
        if (abort && state != ST_IDLE) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (start && legal) state_n = ST_SETUP;
                ST_SETUP: begin
                    state_n = ST_RECT_TOP;
                    if (shp == SHAPE_LINE) state_n = ST_LINE;
`ifdef SHAPE_RASTER_FILL_EN
                    if (shp == SHAPE_FILL) state_n = ST_FILL;
`endif
                end
                ST_RECT_TOP:
                    if (hs && cur_x == max_x)
                        state_n = (max_y == min_y) ? ST_FINISH : ST_RECT_RIGHT;
                ST_RECT_RIGHT:
                    if (hs && cur_y == min_y)
                        state_n = (min_x == max_x) ? ST_FINISH : ST_RECT_BOT;
                ST_RECT_BOT:
                    if (hs && cur_x == min_x)
                        state_n = ((max_y - min_y) < CW'(2)) ? ST_FINISH
                                                             : ST_RECT_LEFT;
                ST_RECT_LEFT:
                    if (hs && cur_y == max_y - CW'(1)) state_n = ST_FINISH;
`ifdef SHAPE_RASTER_FILL_EN
                ST_FILL:
                    if (hs && cur_x == max_x && cur_y == min_y)
                        state_n = ST_FINISH;
`endif
                ST_LINE:
                    if (hs && line_end) state_n = ST_FINISH;
                ST_FINISH: state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        px_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE:   ;
            ST_SETUP:  busy = 1'b1;
            ST_FINISH: done = 1'b1;
            default: begin
                busy     = 1'b1;
                px_valid = 1'b1;
            end
        endcase
    end

    // Command latch, setup arithmetic and coordinate walkers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shp    <= SHAPE_NONE;
            lx0    <= '0;
            ly0    <= '0;
            lx1    <= '0;
            ly1    <= '0;
            min_x  <= '0;
            max_x  <= '0;
            min_y  <= '0;
            max_y  <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (start && legal) begin
                        shp <= shape;
                        lx0 <= x0;
                        ly0 <= y0;
                        lx1 <= x1;
                        ly1 <= y1;
                    end
                ST_SETUP: begin
                    min_x  <= mn_x;
                    max_x  <= mx_x;
                    min_y  <= mn_y;
                    max_y  <= mx_y;
                    dx     <= adx;
                    dy     <= -ady;
                    err    <= adx - ady;
                    sx_neg <= (lx1 < lx0);
                    sy_neg <= (ly1 < ly0);
                    cur_x  <= (shp == SHAPE_LINE) ? lx0 : mn_x;
                    cur_y  <= (shp == SHAPE_LINE) ? ly0 : mx_y;
                end
                ST_RECT_TOP:
                    if (hs) begin
                        if (cur_x != max_x)      cur_x <= cur_x + CW'(1);
                        else if (max_y != min_y) cur_y <= max_y - CW'(1);
                    end
                ST_RECT_RIGHT:
                    if (hs) begin
                        if (cur_y != min_y)      cur_y <= cur_y - CW'(1);
                        else if (min_x != max_x) cur_x <= max_x - CW'(1);
                    end
                ST_RECT_BOT:
                    if (hs) begin
                        if (cur_x != min_x)
                            cur_x <= cur_x - CW'(1);
                        else if ((max_y - min_y) >= CW'(2))
                            cur_y <= min_y + CW'(1);
                    end
                ST_RECT_LEFT:
                    if (hs && cur_y != max_y - CW'(1)) cur_y <= cur_y + CW'(1);
`ifdef SHAPE_RASTER_FILL_EN
                ST_FILL:
                    if (hs) begin
                        if (cur_x != max_x) begin
                            cur_x <= cur_x + CW'(1);
                        end else if (cur_y != min_y) begin
                            cur_x <= min_x;
                            cur_y <= cur_y - CW'(1);
                        end
                    end
`endif
                ST_LINE:
                    if (hs && !line_end) begin
                        cur_x <= bx;
                        cur_y <= by;
                        err   <= berr;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_raster.sv
// tb_shape_raster: directed self-checking bench for shape_raster (CW=8).
// Fill vectors are included when SHAPE_RASTER_FILL_EN is defined.
module tb_shape_raster;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] shape = 2'd0;
    logic [7:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic       abort = 1'b0;
    logic [7:0] px_x, px_y;
    logic       px_valid;
    logic       px_ready = 1'b1;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shape_raster #(.CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .shape    (shape),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .abort    (abort),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command at cycle T; returns positioned at T+2.
    task automatic cmd(input logic [1:0] s, input int a, input int b,
                       input int c, input int d);
        start = 1'b1;
        shape = s;
        x0 = 8'(a);
        y0 = 8'(b);
        x1 = 8'(c);
        y1 = 8'(d);
        tick();
        start = 1'b0;
        shape = 2'd0;
        x0 = 8'hAA;
        y0 = 8'h55;
        x1 = 8'hAA;
        y1 = 8'h55;
        chk("setup_busy", 32'(busy), 1);
        chk("setup_valid", 32'(px_valid), 0);
        tick();
    endtask

    task automatic pix(input string tag, input int ex, input int ey);
        chk({tag, "_valid"}, 32'(px_valid), 1);
        chk({tag, "_x"}, 32'(px_x), 32'(ex));
        chk({tag, "_y"}, 32'(px_y), 32'(ey));
        tick();
    endtask

    task automatic run(input string tag, input int xs[$], input int ys[$]);
        for (int i = 0; i < xs.size(); i++)
            pix($sformatf("%s_p%0d", tag, i), xs[i], ys[i]);
    endtask

    task automatic fin(input string tag);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_done_busy"}, 32'(busy), 0);
        chk({tag, "_done_valid"}, 32'(px_valid), 0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int qx[$];
        int qy[$];

        // Reset state.
        tick();
        tick();
        chk("rst_valid", 32'(px_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_px_x", 32'(px_x), 0);
        chk("rst_px_y", 32'(px_y), 0);
        rst_n = 1'b1;
        tick();

        // Rect outline (2,3)-(5,6).
        cmd(2'd1, 2, 3, 5, 6);
        qx = '{2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 2, 2};
        qy = '{6, 6, 6, 6, 5, 4, 3, 3, 3, 3, 4, 5};
        run("rect", qx, qy);
        fin("rect");

        // Line (0,0)-(7,3).
        cmd(2'd2, 0, 0, 7, 3);
        qx = '{0, 1, 2, 3, 4, 5, 6, 7};
        qy = '{0, 0, 1, 1, 2, 2, 3, 3};
        run("line", qx, qy);
        fin("line");

        // Reversed line (7,3)-(0,0).
        cmd(2'd2, 7, 3, 0, 0);
        qx = '{7, 6, 5, 4, 3, 2, 1, 0};
        qy = '{3, 3, 2, 2, 1, 1, 0, 0};
        run("rline", qx, qy);
        fin("rline");

        // Single-pixel rect.
        cmd(2'd1, 4, 4, 4, 4);
        pix("dot", 4, 4);
        fin("dot");

        // One-column rect (1,2)-(1,6).
        cmd(2'd1, 1, 6, 1, 2);
        qx = '{1, 1, 1, 1, 1};
        qy = '{6, 5, 4, 3, 2};
        run("col", qx, qy);
        fin("col");

        // Vertical line (3,5)-(3,1).
        cmd(2'd2, 3, 5, 3, 1);
        qx = '{3, 3, 3, 3, 3};
        qy = '{5, 4, 3, 2, 1};
        run("vline", qx, qy);
        fin("vline");

        // 2x2 rect at the top of the coordinate range.
        cmd(2'd1, 255, 255, 254, 254);
        qx = '{254, 255, 255, 254};
        qy = '{255, 255, 254, 254};
        run("edge", qx, qy);
        fin("edge");

        // Backpressure: ready low for 3 cycles on pixel 2.
        cmd(2'd1, 2, 3, 5, 6);
        pix("bp_p0", 2, 6);
        px_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d_valid", i), 32'(px_valid), 1);
            chk($sformatf("bp_hold%0d_x", i), 32'(px_x), 3);
            chk($sformatf("bp_hold%0d_y", i), 32'(px_y), 6);
            tick();
        end
        px_ready = 1'b1;
        qx = '{3, 4, 5, 5, 5, 5, 4, 3, 2, 2, 2};
        qy = '{6, 6, 6, 5, 4, 3, 3, 3, 3, 4, 5};
        run("bp", qx, qy);
        fin("bp");

        // Abort on pixel 4 of a line.
        cmd(2'd2, 0, 0, 7, 3);
        pix("ab_p0", 0, 0);
        pix("ab_p1", 1, 0);
        pix("ab_p2", 2, 1);
        chk("ab_p3_valid", 32'(px_valid), 1);
        chk("ab_p3_x", 32'(px_x), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(px_valid), 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        tick();
        chk("ab_done2", 32'(done), 0);
        chk("ab_busy2", 32'(busy), 0);

        // Fresh line; a start while busy must be ignored.
        cmd(2'd2, 2, 2, 4, 3);
        pix("fr_p0", 2, 2);
        start = 1'b1;
        shape = 2'd1;
        x0 = 8'd0;
        y0 = 8'd0;
        x1 = 8'd9;
        y1 = 8'd9;
        pix("fr_p1", 3, 3);
        start = 1'b0;
        shape = 2'd0;
        pix("fr_p2", 4, 3);
        fin("fr");

        // Asynchronous reset mid-command.
        cmd(2'd1, 2, 3, 5, 6);
        pix("rs_p0", 2, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(px_valid), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_px_x", 32'(px_x), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_done", 32'(done), 0);
        chk("rs_idle_busy", 32'(busy), 0);

        // shape=0 never starts.
        start = 1'b1;
        shape = 2'd0;
        tick();
        start = 1'b0;
        chk("none_busy", 32'(busy), 0);
        tick();
        chk("none_done", 32'(done), 0);

`ifdef SHAPE_RASTER_FILL_EN
        // Filled rect (1,1)-(3,2).
        cmd(2'd3, 1, 1, 3, 2);
        qx = '{1, 2, 3, 1, 2, 3};
        qy = '{2, 2, 2, 1, 1, 1};
        run("fill", qx, qy);
        fin("fill");
`else
        // shape=3 behaves like shape=0.
        start = 1'b1;
        shape = 2'd3;
        x0 = 8'd1;
        y0 = 8'd1;
        x1 = 8'd3;
        y1 = 8'd2;
        tick();
        start = 1'b0;
        chk("nofill_busy", 32'(busy), 0);
        chk("nofill_valid", 32'(px_valid), 0);
        tick();
        chk("nofill_busy2", 32'(busy), 0);
        chk("nofill_done", 32'(done), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
